sw_poll_sched: RTL and testbench

- Avalon-MM read master that sequences periodic reads of the switch input PIO data register (address 0).
- Debounces the sampled word: a value must be seen on STABLE_CNT consecutive polls before it is accepted.
- Each debounced change is reported to the CPU/fabric side as an event on a valid/ready interface.
- Sits between the switch PIO slave and the Nios/system logic, so software never busy-polls the PIO.

---
 rtl/sw_poll_pkg.sv | 21 ++
 rtl/sw_poll_sched_debounce.sv | 82 ++++++++
 rtl/sw_poll_sched.sv | 202 ++++++++++++++++++++
 tb/tb_sw_poll_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_poll_pkg.sv
// ---------------------------------------------------------------------------
// sw_poll_pkg
// Shared definitions for the switch-poll scheduler:
//   - poll_state_e   : read-sequence FSM states
//   - PIO_DATA_ADDR  : address of the switch PIO data register
//   - STABLE_W       : width of the debounce stable counter
// ---------------------------------------------------------------------------
package sw_poll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } poll_state_e;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  localparam int STABLE_W = 8;

endpackage : sw_poll_pkg

// File: rtl/sw_poll_sched_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
// Holds the candidate value, the saturating stable counter and the debounced
// switch state. A new sample is evaluated only in the cycle sample_valid is
// high. When the candidate has been seen STABLE_CNT times in a row and it
// differs from the current debounced value, a one-cycle commit is raised
// together with the new value and the bits that changed.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   sample_valid in   one-cycle strobe: sample carries fresh PIO data
//   sample       in   sampled switch word
//   sw_state     out  current debounced value (registered)
//   commit       out  a new value is being committed this cycle
//   commit_data  out  value being committed
//   commit_diff  out  old debounced value XOR committed value
// ---------------------------------------------------------------------------
module sw_debounce
  import sw_poll_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int STABLE_CNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] sw_state,
  output logic              commit,
  output logic [DATA_W-1:0] commit_data,
  output logic [DATA_W-1:0] commit_diff
);

  localparam logic [STABLE_W-1:0] STABLE_LIM = STABLE_W'(STABLE_CNT);

  logic [DATA_W-1:0]   cand_q,  cand_d;
  logic [DATA_W-1:0]   state_q, state_d;
  logic [STABLE_W-1:0] cnt_q,   cnt_d;

  // NOTE: every signal assigned in always_comb gets its default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    commit  = 1'b0;
    if (sample_valid) begin
      if (sample == cand_q) begin
        if (cnt_q < STABLE_LIM) cnt_d = cnt_q + STABLE_W'(1);
      end else begin
        cand_d = sample;
        cnt_d  = STABLE_W'(1);
      end
      // Decision uses the updated candidate/count, so STABLE_CNT=1 commits
      // every changed sample on its first appearance.
      if ((cnt_d >= STABLE_LIM) && (cand_d != state_q)) begin
        commit  = 1'b1;
        state_d = cand_d;
      end
    end
  end

  assign commit_data = cand_d;
  assign commit_diff = state_q ^ cand_d;
  assign sw_state    = state_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q  <= '0;
      cnt_q   <= '0;
      state_q <= '0;
    end else begin
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

endmodule : sw_debounce

// File: rtl/sw_poll_sched.sv
// ---------------------------------------------------------------------------
// sw_poll_sched
// Avalon-MM read master that polls the switch PIO data register every
// POLL_DIV cycles, debounces the sampled word and reports each debounced
// change as an event on a valid/ready interface. A commit that arrives while
// an earlier event is still unaccepted is merged into it and flags overflow.
//
// Optional feature (macro SW_POLL_IRQ_EN): adds irq_mask input and a
// registered irq output = evt_valid & |(evt_changed & irq_mask).
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   enable        1 = polling runs; 0 = tick counter held at 0
//   m_address     PIO register address (always 0)
//   m_read        one-cycle read strobe
//   m_readdata    PIO read data
//   sw_state      current debounced switch value
//   evt_valid     event pending
//   evt_ready     consumer accepts the event
//   evt_data      committed value carried by the event
//   evt_changed   bits differing from the previously committed value
//   overflow      sticky: an event was merged while one was unaccepted
//   overflow_clr  clears overflow (a simultaneous set wins)
//   busy          read sequence in progress
//   irq_mask, irq (SW_POLL_IRQ_EN only)
// ---------------------------------------------------------------------------
module sw_poll_sched
  import sw_poll_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int POLL_DIV     = 50000,
  parameter int STABLE_CNT   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [1:0]        m_address,
  output logic              m_read,
  input  logic [DATA_W-1:0] m_readdata,
  output logic [DATA_W-1:0] sw_state,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_data,
  output logic [DATA_W-1:0] evt_changed,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic              busy
`ifdef SW_POLL_IRQ_EN
  ,
  input  logic [DATA_W-1:0] irq_mask,
  output logic              irq
`endif
);

  localparam int TICK_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(POLL_DIV - 1);
  localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);

  // -------------------------------------------------------------------------
  // Poll tick
  // -------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_q;
  logic              tick;

  assign tick = enable && (tick_q == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset || !enable) tick_q <= '0;
    else if (tick)        tick_q <= '0;
    else                  tick_q <= tick_q + TICK_W'(1);
  end

  // -------------------------------------------------------------------------
  // Read-sequence FSM. Once started it always runs through CAPTURE, even if
  // enable drops; ticks seen outside IDLE are simply ignored.
  // -------------------------------------------------------------------------
  poll_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_q,  wait_d;
  logic              sample_valid;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    m_read       = 1'b0;
    sample_valid = 1'b0;
    case (state_q)
      IDLE:    if (tick) state_d = READ;
      READ: begin
        m_read  = 1'b1;
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == WAIT_LAST) state_d = CAPTURE;
        else                     wait_d  = wait_q + WAIT_W'(1);
      end
      CAPTURE: begin
        sample_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign m_address = PIO_DATA_ADDR;
  assign busy      = (state_q != IDLE);

  // -------------------------------------------------------------------------
  // Debounce
  // -------------------------------------------------------------------------
  logic              commit;
  logic [DATA_W-1:0] commit_data;
  logic [DATA_W-1:0] commit_diff;

  sw_debounce #(
    .DATA_W     (DATA_W),
    .STABLE_CNT (STABLE_CNT)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (m_readdata),
    .sw_state     (sw_state),
    .commit       (commit),
    .commit_data  (commit_data),
    .commit_diff  (commit_diff)
  );

  // -------------------------------------------------------------------------
  // Event register and handshake
  // -------------------------------------------------------------------------
  logic              evt_valid_q,   evt_valid_d;
  logic [DATA_W-1:0] evt_data_q,    evt_data_d;
  logic [DATA_W-1:0] evt_changed_q, evt_changed_d;
  logic              overflow_q,    overflow_d;
  logic              xfer;

  assign xfer = evt_valid_q && evt_ready;

  always_comb begin
    evt_valid_d   = evt_valid_q;
    evt_data_d    = evt_data_q;
    evt_changed_d = evt_changed_q;
    overflow_d    = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (xfer)         evt_valid_d = 1'b0;
    if (commit) begin
      evt_valid_d = 1'b1;
      evt_data_d  = commit_data;
      if (evt_valid_q && !xfer) begin
        // Previous event still owned by us: fold the new diff into it.
        evt_changed_d = evt_changed_q | commit_diff;
        overflow_d    = 1'b1;
      end else begin
        evt_changed_d = commit_diff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid_q   <= 1'b0;
      evt_data_q    <= '0;
      evt_changed_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      evt_valid_q   <= evt_valid_d;
      evt_data_q    <= evt_data_d;
      evt_changed_q <= evt_changed_d;
      overflow_q    <= overflow_d;
    end
  end

  assign evt_valid   = evt_valid_q;
  assign evt_data    = evt_data_q;
  assign evt_changed = evt_changed_q;
  assign overflow    = overflow_q;

`ifdef SW_POLL_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= evt_valid_q && |(evt_changed_q & irq_mask);
  end

  assign irq = irq_q;
`endif

endmodule : sw_poll_sched

// File: tb/tb_sw_poll_sched.sv
// ---------------------------------------------------------------------------
// tb_sw_poll_sched
// Directed bench for sw_poll_sched with POLL_DIV=10, STABLE_CNT=3,
// READ_LATENCY=1. Each table row is one poll: the switch word presented on
// m_readdata, the evt_ready/overflow_clr levels applied in the CAPTURE cycle
// and the expected outputs once the poll has settled. irq is checked with
// irq_mask=0x2 when SW_POLL_IRQ_EN is defined.
// ---------------------------------------------------------------------------
module tb_sw_poll_sched;

  localparam int DATA_W     = 32;
  localparam int POLL_DIV   = 10;
  localparam int STABLE_CNT = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [1:0]        m_address;
  logic              m_read;
  logic [DATA_W-1:0] m_readdata;
  logic [DATA_W-1:0] sw_state;
  logic              evt_valid;
  logic              evt_ready;
  logic [DATA_W-1:0] evt_data;
  logic [DATA_W-1:0] evt_changed;
  logic              overflow;
  logic              overflow_clr;
  logic              busy;
`ifdef SW_POLL_IRQ_EN
  logic [DATA_W-1:0] irq_mask;
  logic              irq;
`endif

  always #5 clk = ~clk;

  sw_poll_sched #(
    .DATA_W       (DATA_W),
    .POLL_DIV     (POLL_DIV),
    .STABLE_CNT   (STABLE_CNT),
    .READ_LATENCY (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .m_address    (m_address),
    .m_read       (m_read),
    .m_readdata   (m_readdata),
    .sw_state     (sw_state),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_data     (evt_data),
    .evt_changed  (evt_changed),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .busy         (busy)
`ifdef SW_POLL_IRQ_EN
    ,
    .irq_mask     (irq_mask),
    .irq          (irq)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Counts falling edges until m_read is seen high; n = -1 if not within limit.
  task automatic count_to_read(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (m_read) begin
        n = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [31:0] sample;
    bit          rdy;
    bit          clr;
    logic [31:0] sw;
    bit          v;
    logic [31:0] d;
    logic [31:0] ch;
    bit          ov;
    bit          irq;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [31:0] s, input bit r, input bit c,
                              input logic [31:0] sw, input bit v,
                              input logic [31:0] d, input logic [31:0] ch,
                              input bit ov, input bit irq_e);
    vec_t e;
    e.sample = s;  e.rdy = r; e.clr = c;
    e.sw = sw;     e.v = v;   e.d = d;  e.ch = ch;
    e.ov = ov;     e.irq = irq_e;
    vecs.push_back(e);
  endfunction

  initial begin
    int n;
    vec_t e;

    //   sample rdy clr | sw   v  data  chg  ov irq
    // Bounce 5/0/5/0: never stable, nothing commits.
    add(32'h5, 0, 0,  32'h0, 0, 32'h0, 32'h0, 0, 0);
    add(32'h0, 0, 0,  32'h0, 0, 32'h0, 32'h0, 0, 0);
    add(32'h5, 0, 0,  32'h0, 0, 32'h0, 32'h0, 0, 0);
    add(32'h0, 0, 0,  32'h0, 0, 32'h0, 32'h0, 0, 0);
    // 0 -> 5 commits on the third consecutive sample.
    add(32'h5, 0, 0,  32'h0, 0, 32'h0, 32'h0, 0, 0);
    add(32'h5, 0, 0,  32'h0, 0, 32'h0, 32'h0, 0, 0);
    add(32'h5, 0, 0,  32'h5, 1, 32'h5, 32'h5, 0, 0);
    // Accept, then 5 -> 0 with ready already high (valid was 0 at commit).
    add(32'h5, 1, 0,  32'h5, 0, 32'h5, 32'h5, 0, 0);
    add(32'h0, 1, 0,  32'h5, 0, 32'h5, 32'h5, 0, 0);
    add(32'h0, 1, 0,  32'h5, 0, 32'h5, 32'h5, 0, 0);
    add(32'h0, 1, 0,  32'h0, 1, 32'h0, 32'h5, 0, 0);
    add(32'h0, 1, 0,  32'h0, 0, 32'h0, 32'h5, 0, 0);
    // 0 -> 1 then 1 -> 3 without acceptance: merge and overflow.
    add(32'h1, 0, 0,  32'h0, 0, 32'h0, 32'h5, 0, 0);
    add(32'h1, 0, 0,  32'h0, 0, 32'h0, 32'h5, 0, 0);
    add(32'h1, 0, 0,  32'h1, 1, 32'h1, 32'h1, 0, 0);
    add(32'h3, 0, 0,  32'h1, 1, 32'h1, 32'h1, 0, 0);
    add(32'h3, 0, 0,  32'h1, 1, 32'h1, 32'h1, 0, 0);
    add(32'h3, 0, 0,  32'h3, 1, 32'h3, 32'h3, 1, 1);
    // overflow_clr, then accept.
    add(32'h3, 0, 1,  32'h3, 1, 32'h3, 32'h3, 0, 1);
    add(32'h3, 1, 0,  32'h3, 0, 32'h3, 32'h3, 0, 0);
    // 3 -> 7 pending, then 7 -> F commits in the very cycle 7 is accepted.
    add(32'h7, 0, 0,  32'h3, 0, 32'h3, 32'h3, 0, 0);
    add(32'h7, 0, 0,  32'h3, 0, 32'h3, 32'h3, 0, 0);
    add(32'h7, 0, 0,  32'h7, 1, 32'h7, 32'h4, 0, 0);
    add(32'hF, 0, 0,  32'h7, 1, 32'h7, 32'h4, 0, 0);
    add(32'hF, 0, 0,  32'h7, 1, 32'h7, 32'h4, 0, 0);
    add(32'hF, 1, 0,  32'hF, 1, 32'hF, 32'h8, 0, 0);
    // F -> 0 merge with overflow_clr in the same cycle: set wins.
    add(32'h0, 0, 0,  32'hF, 1, 32'hF, 32'h8, 0, 0);
    add(32'h0, 0, 0,  32'hF, 1, 32'hF, 32'h8, 0, 0);
    add(32'h0, 0, 1,  32'h0, 1, 32'h0, 32'hF, 1, 1);
    // Accept and clear together.
    add(32'h0, 1, 1,  32'h0, 0, 32'h0, 32'hF, 0, 0);

    reset        = 1'b1;
    enable       = 1'b0;
    m_readdata   = '0;
    evt_ready    = 1'b0;
    overflow_clr = 1'b0;
`ifdef SW_POLL_IRQ_EN
    irq_mask     = 32'h2;
`endif

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_m_read",      m_read,      0);
    check("rst_m_address",   m_address,   0);
    check("rst_busy",        busy,        0);
    check("rst_sw_state",    sw_state,    0);
    check("rst_evt_valid",   evt_valid,   0);
    check("rst_evt_data",    evt_data,    0);
    check("rst_evt_changed", evt_changed, 0);
    check("rst_overflow",    overflow,    0);
`ifdef SW_POLL_IRQ_EN
    check("rst_irq",         irq,         0);
`endif
    reset = 1'b0;

    // ---- disabled: no polling ----
    count_to_read(25, n);
    check("no_read_disabled", n, -1);

    // ---- poll period and read-sequence shape ----
    enable = 1'b1;
    count_to_read(40, n);
    check("first_read_delay", n, POLL_DIV);
    check("read_addr",  m_address, 0);
    check("read_busy",  busy, 1);
    @(negedge clk);
    check("read_one_cycle", m_read, 0);
    check("wait_busy", busy, 1);
    @(negedge clk);
    check("capture_busy", busy, 1);
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    count_to_read(40, n);
    check("read_period", n, POLL_DIV - 5);
    count_to_read(40, n);
    check("read_period2", n, POLL_DIV);
    repeat (4) @(negedge clk);

    // ---- table: one poll per row ----
    foreach (vecs[i]) begin
      e = vecs[i];
      m_readdata = e.sample;
      count_to_read(40, n);
      if (n < 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL v%0d_no_read: got none expected m_read", i);
      end
      @(negedge clk);                 // WAIT
      @(negedge clk);                 // CAPTURE
      evt_ready    = e.rdy;
      overflow_clr = e.clr;
      @(negedge clk);
      evt_ready    = 1'b0;
      overflow_clr = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_sw_state", i),    sw_state,    e.sw);
      check($sformatf("v%0d_evt_valid", i),   evt_valid,   32'(e.v));
      check($sformatf("v%0d_evt_data", i),    evt_data,    e.d);
      check($sformatf("v%0d_evt_changed", i), evt_changed, e.ch);
      check($sformatf("v%0d_overflow", i),    overflow,    32'(e.ov));
`ifdef SW_POLL_IRQ_EN
      check($sformatf("v%0d_irq", i),         irq,         32'(e.irq));
`endif
    end

    // ---- enable dropped mid-sequence: sequence still completes ----
    count_to_read(40, n);
    check("pre_disable_read", n, POLL_DIV - 4);
    enable = 1'b0;
    @(negedge clk);
    check("dis_wait_busy", busy, 1);
    @(negedge clk);
    check("dis_capture_busy", busy, 1);
    @(negedge clk);
    check("dis_back_idle", busy, 0);
    count_to_read(25, n);
    check("dis_no_read", n, -1);
    enable = 1'b1;
    count_to_read(40, n);
    check("reenable_delay", n, POLL_DIV);

    // ---- reset in the middle of a read ----
    repeat (3) @(negedge clk);
    count_to_read(40, n);
    check("pre_reset_read", n, POLL_DIV - 3);
    m_readdata = 32'hA;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy",   busy,   0);
    check("midrst_m_read", m_read, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_idle_busy", busy, 0);
    check("midrst_sw_state",  sw_state, 0);
    check("midrst_evt_valid", evt_valid, 0);
    count_to_read(40, n);
    check("post_reset_delay", n, POLL_DIV - 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_sw_poll_sched
